// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
//   - register address / data widths
//   - architecturally protected register numbers
//   - reg_writable(): true when the write port may target a register
//   - wb_entry_t: one buffered write-back (destination + result)
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_K0   = 5'd26;
    localparam logic [ADDR_W-1:0] REG_K1   = 5'd27;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic signed [DATA_W-1:0] data;
    } wb_entry_t;

    // $0 is hardwired and $k0/$k1 belong to the exception handler, so the
    // write port must never carry them.
    function automatic logic reg_writable(input logic [ADDR_W-1:0] addr);
        return !((addr == REG_ZERO) || (addr == REG_K0) || (addr == REG_K1));
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// wb_fifo: small synchronous FIFO holding buffered mul/div write-backs.
//   clk    : clock, all updates on rising edge
//   rst_n  : synchronous active-low reset (empties the FIFO)
//   push   : write din this cycle (taken when not full, or full with pop)
//   din    : entry to store
//   pop    : discard the head this cycle (ignored when empty)
//   dout   : current head entry (valid when !empty)
//   full   : count == DEPTH
//   empty  : count == 0
//   count  : number of stored entries
// The head is read straight from the array so the arbiter can select it in
// the same cycle; the storage is tiny, so a distributed RAM is the target.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    // When full, a push only fits because the head leaves in the same edge.
    assign do_push = push && (!full || do_pop);

    // Storage has no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges ALU write-backs and buffered mul/div results
// onto the register file's single write port and tracks outstanding mul/div
// destinations for decode hazard detection.
//   Clk, Rst_n                     : clock, synchronous active-low reset
//   AluValid/AluWAddr/AluWData     : ALU write-back, no backpressure
//   AluHold                        : registered, ALU must stay idle while 1
//   MdValid/MdReady/MdWAddr/MdWData: mul/div result handshake into the FIFO
//   IssueMd/IssueWAddr             : mul/div issued, mark destination pending
//   ReadReg1/ReadReg2/DestReg      : decode registers checked for hazards
//   Hazard                         : combinational, any checked reg pending
//   RegWrite/WAddr/WData           : registered write port
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     AluValid,
    input  logic [4:0]               AluWAddr,
    input  logic signed [31:0]       AluWData,
    output logic                     AluHold,
    input  logic                     MdValid,
    output logic                     MdReady,
    input  logic [4:0]               MdWAddr,
    input  logic signed [31:0]       MdWData,
    input  logic                     IssueMd,
    input  logic [4:0]               IssueWAddr,
    input  logic [4:0]               ReadReg1,
    input  logic [4:0]               ReadReg2,
    input  logic [4:0]               DestReg,
    output logic                     Hazard,
    output logic                     RegWrite,
    output logic [4:0]               WAddr,
    output logic signed [31:0]       WData
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t               md_entry;
    wb_entry_t               head_entry;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        count_next;

    logic                    alu_sel;
    logic                    md_accept;

    logic [NUM_REGS-1:0]     pending_reg;
    logic [NUM_REGS-1:0]     pending_next;

    logic                    reg_write_reg;
    logic [ADDR_W-1:0]       waddr_reg;
    logic signed [DATA_W-1:0] wdata_reg;
    logic                    alu_hold_reg;

    // ---------------------------------------------------------------
    // Mul/div result FIFO
    // ---------------------------------------------------------------
    // Held low in reset so no result is consumed while the pipeline flushes.
    assign MdReady   = !fifo_full && Rst_n;
    assign md_accept = MdValid && MdReady;
    // Results aimed at protected registers are consumed but never stored.
    assign fifo_push = md_accept && reg_writable(MdWAddr);
    assign md_entry  = '{addr: MdWAddr, data: MdWData};

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (fifo_push),
        .din   (md_entry),
        .pop   (fifo_pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------------------------------------------------------
    // Arbitration: a writable ALU result always wins, the FIFO head is
    // taken (and popped) only when the ALU slot is free.
    // ---------------------------------------------------------------
    assign alu_sel  = AluValid && reg_writable(AluWAddr);
    assign fifo_pop = !alu_sel && !fifo_empty;

    always_comb begin
        count_next = fifo_count;
        if (fifo_push && !fifo_pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!fifo_push && fifo_pop) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            reg_write_reg <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
            alu_hold_reg  <= 1'b0;
        end else begin
            reg_write_reg <= alu_sel || fifo_pop;
            if (alu_sel) begin
                waddr_reg <= AluWAddr;
                wdata_reg <= AluWData;
            end else if (fifo_pop) begin
                waddr_reg <= head_entry.addr;
                wdata_reg <= head_entry.data;
            end
            // Holding the ALU off while full guarantees the next cycle
            // drains the head, so the FIFO can never stay full forever.
            alu_hold_reg  <= (count_next == CNT_W'(DEPTH));
        end
    end

    assign RegWrite = reg_write_reg;
    assign WAddr    = waddr_reg;
    assign WData    = wdata_reg;
    assign AluHold  = alu_hold_reg;

    // ---------------------------------------------------------------
    // Pending-write scoreboard. The clear happens on the edge that
    // registers the FIFO-sourced write, so Hazard drops in the cycle the
    // register file performs it. A same-cycle reissue to that register
    // keeps the bit set.
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            logic bit_set;
            logic bit_clr;
            assign bit_set = IssueMd && reg_writable(IssueWAddr)
                             && (IssueWAddr == ADDR_W'(gi));
            assign bit_clr = fifo_pop && (head_entry.addr == ADDR_W'(gi));
            assign pending_next[gi] = bit_set || (pending_reg[gi] && !bit_clr);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign Hazard = ((ReadReg1 != REG_ZERO) && pending_reg[ReadReg1])
                 || ((ReadReg2 != REG_ZERO) && pending_reg[ReadReg2])
                 || ((DestReg  != REG_ZERO) && pending_reg[DestReg]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              AluValid;
    logic [4:0]        AluWAddr;
    logic signed [31:0] AluWData;
    logic              AluHold;
    logic              MdValid;
    logic              MdReady;
    logic [4:0]        MdWAddr;
    logic signed [31:0] MdWData;
    logic              IssueMd;
    logic [4:0]        IssueWAddr;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic [4:0]        DestReg;
    logic              Hazard;
    logic              RegWrite;
    logic [4:0]        WAddr;
    logic signed [31:0] WData;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_write_arbiter #(.DEPTH(4)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .AluValid   (AluValid),
        .AluWAddr   (AluWAddr),
        .AluWData   (AluWData),
        .AluHold    (AluHold),
        .MdValid    (MdValid),
        .MdReady    (MdReady),
        .MdWAddr    (MdWAddr),
        .MdWData    (MdWData),
        .IssueMd    (IssueMd),
        .IssueWAddr (IssueWAddr),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .DestReg    (DestReg),
        .Hazard     (Hazard),
        .RegWrite   (RegWrite),
        .WAddr      (WAddr),
        .WData      (WData)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
            $display("check %-18s observed %h expected %h", tag, obs, exp);
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks a port write; a slot where RegWrite is expected low ignores addr/data.
    task automatic check_port(input string tag, input logic we,
                              input logic [4:0] addr, input logic [31:0] data);
        check({tag, ".we"}, 32'(RegWrite), 32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(WAddr), 32'(addr));
            check({tag, ".data"}, WData, data);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        AluValid = 1'b1; AluWAddr = 5'd8; AluWData = 32'sd1;
        MdValid = 1'b1;  MdWAddr = 5'd3;  MdWData = 32'sd2;
        IssueMd = 1'b0;  IssueWAddr = 5'd0;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0; DestReg = 5'd0;

        // Reset held 3 cycles with traffic offered
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.regwrite", 32'(RegWrite), 32'd0);
            check("rst.mdready",  32'(MdReady),  32'd0);
            check("rst.hazard",   32'(Hazard),   32'd0);
        end
        Rst_n = 1'b1; AluValid = 1'b0; MdValid = 1'b0;
        tick();
        check("post_rst.mdready", 32'(MdReady), 32'd1);
        check("post_rst.hold",    32'(AluHold), 32'd0);
        check("post_rst.we",      32'(RegWrite), 32'd0);
        check("post_rst.waddr",   32'(WAddr), 32'd0);
        check("post_rst.wdata",   WData, 32'd0);

        // ALU pass-through and protected-address filtering
        AluValid = 1'b1; AluWAddr = 5'd8; AluWData = 32'h12345678;
        tick();
        AluValid = 1'b0;
        check_port("alu8", 1'b1, 5'd8, 32'h12345678);
        AluValid = 1'b1; AluWAddr = 5'd26; AluWData = 32'h0000dead;
        tick();
        AluValid = 1'b0;
        check_port("alu26", 1'b0, 5'd0, 32'd0);
        AluValid = 1'b1; AluWAddr = 5'd0; AluWData = 32'h0000beef;
        tick();
        AluValid = 1'b0;
        check_port("alu0", 1'b0, 5'd0, 32'd0);

        // Scoreboard: issue to $9, then result arrives through the FIFO
        ReadReg2 = 5'd9;
        #1 check("sb.pre_issue", 32'(Hazard), 32'd0);
        IssueMd = 1'b1; IssueWAddr = 5'd9;
        tick();
        IssueMd = 1'b0;
        check("sb.rr2_hazard", 32'(Hazard), 32'd1);
        ReadReg2 = 5'd0; DestReg = 5'd9;
        #1 check("sb.dest_hazard", 32'(Hazard), 32'd1);
        DestReg = 5'd0; ReadReg2 = 5'd9;
        MdValid = 1'b1; MdWAddr = 5'd9; MdWData = -32'sd7;
        #1 check("sb.mdready", 32'(MdReady), 32'd1);
        tick();                                   // accept edge
        MdValid = 1'b0;
        check_port("sb.acc+1", 1'b0, 5'd0, 32'd0);
        check("sb.acc+1.hazard", 32'(Hazard), 32'd1);
        tick();                                   // edge registering the write
        check_port("sb.md9", 1'b1, 5'd9, 32'hFFFFFFF9);
        check("sb.md9.hazard", 32'(Hazard), 32'd0);
        tick();
        check_port("sb.idle", 1'b0, 5'd0, 32'd0);
        ReadReg2 = 5'd0;

        // Contention: ALU every cycle while four mul/div results arrive
        for (int i = 0; i < 4; i++) begin
            AluValid = 1'b1; AluWAddr = 5'(1 + i); AluWData = 32'(101 + i);
            MdValid  = 1'b1; MdWAddr  = 5'(10 + i); MdWData = 32'(1010 + i);
            tick();
            check_port($sformatf("cont.alu%0d", 1 + i), 1'b1, 5'(1 + i), 32'(101 + i));
        end
        MdValid = 1'b0; AluValid = 1'b0;
        check("cont.full.hold",    32'(AluHold), 32'd1);
        check("cont.full.mdready", 32'(MdReady), 32'd0);
        tick();                                   // held cycle drains $10
        check_port("cont.md10", 1'b1, 5'd10, 32'd1010);
        check("cont.unhold", 32'(AluHold), 32'd0);
        check("cont.mdready", 32'(MdReady), 32'd1);
        AluValid = 1'b1; AluWAddr = 5'd5; AluWData = 32'd105;
        tick();
        AluValid = 1'b0;
        check_port("cont.alu5", 1'b1, 5'd5, 32'd105);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_port($sformatf("cont.md%0d", 10 + i), 1'b1, 5'(10 + i), 32'(1010 + i));
        end
        tick();
        check_port("cont.empty", 1'b0, 5'd0, 32'd0);

        // Simultaneous set and clear of pending[5]
        IssueMd = 1'b1; IssueWAddr = 5'd5;
        tick();
        IssueMd = 1'b0;
        MdValid = 1'b1; MdWAddr = 5'd5; MdWData = 32'sd55;
        tick();                                   // accept; head selected next
        MdValid = 1'b0;
        IssueMd = 1'b1; IssueWAddr = 5'd5; ReadReg1 = 5'd5;
        tick();
        IssueMd = 1'b0;
        check_port("sc.md5", 1'b1, 5'd5, 32'd55);
        check("sc.hazard", 32'(Hazard), 32'd1);
        tick();
        check("sc.hazard_hold", 32'(Hazard), 32'd1);
        MdValid = 1'b1; MdWAddr = 5'd5; MdWData = 32'sd56;
        tick();
        MdValid = 1'b0;
        tick();
        check_port("sc.md5b", 1'b1, 5'd5, 32'd56);
        check("sc.hazard_clr", 32'(Hazard), 32'd0);
        ReadReg1 = 5'd0;

        // Discard of protected destinations
        MdValid = 1'b1; MdWAddr = 5'd0; MdWData = 32'sd999;
        IssueMd = 1'b1; IssueWAddr = 5'd26;
        #1 check("dis.mdready", 32'(MdReady), 32'd1);
        tick();
        MdValid = 1'b0; IssueMd = 1'b0;
        check("dis.count", 32'(dut.fifo_count), 32'd0);
        ReadReg1 = 5'd26;
        #1 check("dis.k0_hazard", 32'(Hazard), 32'd0);
        ReadReg1 = 5'd0;
        tick();
        check_port("dis.port1", 1'b0, 5'd0, 32'd0);
        tick();
        check_port("dis.port2", 1'b0, 5'd0, 32'd0);

        // Reset mid-operation loses FIFO contents and pending bits
        MdValid = 1'b1; MdWAddr = 5'd7; MdWData = 32'sd77;
        IssueMd = 1'b1; IssueWAddr = 5'd7;
        tick();
        MdValid = 1'b0; IssueMd = 1'b0;
        Rst_n = 1'b0; ReadReg1 = 5'd7;
        tick();
        check("mid_rst.hazard", 32'(Hazard), 32'd0);
        check("mid_rst.count", 32'(dut.fifo_count), 32'd0);
        check("mid_rst.we", 32'(RegWrite), 32'd0);
        Rst_n = 1'b1;
        tick();
        check_port("mid_rst.after", 1'b0, 5'd0, 32'd0);
        ReadReg1 = 5'd0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port arbiter and pending-write scoreboard sitting between the pipeline's result producers and the register file's single write port (`RegWrite`/`WAddr`/`WData`, sampled by the register file on the falling edge). It merges one-per-cycle ALU write-backs with out-of-order multiply/divide results buffered in a small FIFO. It tracks destinations of outstanding mul/div operations so decode can stall on RAW/WAW hazards. Protected registers $0, $26 and $27 are filtered here, so the write port never carries them.

## Interface
- `DEPTH`, 4: mul/div result FIFO entries (power of two, ≥2).
- `Clk` in 1: clock; all state updates on rising edge.
- `Rst_n` in 1: synchronous, active-low reset.
- `AluValid` in 1: ALU write-back present this cycle; no backpressure.
- `AluWAddr` in 5: ALU destination register.
- `AluWData` in 32 signed: ALU result.
- `AluHold` out 1: registered; pipeline must not assert `AluValid` in a cycle where `AluHold`=1.
- `MdValid` in 1: mul/div result offered.
- `MdReady` out 1: FIFO can accept; transfer when `MdValid && MdReady`.
- `MdWAddr` in 5, `MdWData` in 32 signed: mul/div destination and result.
- `IssueMd` in 1, `IssueWAddr` in 5: mul/div issued this cycle; mark destination pending.
- `ReadReg1`, `ReadReg2`, `DestReg` in 5 each: operands and destination of the instruction in decode.
- `Hazard` out 1: combinational; any of the three is pending and nonzero.
- `RegWrite` out 1, `WAddr` out 5, `WData` out 32 signed: registered write port to the register file.

## Operation
- Writable(r) = r ∉ {0, 26, 27}.
- ALU input with non-writable `AluWAddr`: ignored. No write, no hold effect.
- Accepted mul/div result with non-writable address: consumed and discarded, not pushed. Its pending bit is not touched, because it was never set.
- Selection each cycle, in priority order:
  - valid writable ALU input;
  - else FIFO head, if non-empty;
  - else idle, so next `RegWrite`=0.
- Winner is registered into `RegWrite`/`WAddr`/`WData`. A FIFO head is popped only when selected.
- `MdReady` = !full && `Rst_n`. A push and a pop in the same cycle are allowed when full; count stays unchanged, but `MdReady` stays 0 that cycle (no combinational path from pop).
- `AluHold` is registered to 1 when the FIFO count after this edge equals `DEPTH`; otherwise it is 0. A held cycle therefore always drains the head.
- Scoreboard: 32-bit pending vector.
  - `IssueMd` with writable `IssueWAddr` sets that bit.
  - A FIFO-sourced write to register r clears bit r.
  - Set and clear of the same bit in the same cycle: set wins.
- Decode must not issue a mul/div to a pending destination. `Hazard` covers this through `DestReg`.
- ALU writes never touch the scoreboard.
- `Hazard` ignores register 0.

## Timing
- Reset values:
  - `RegWrite`=0, `WAddr`=0, `WData`=0, `AluHold`=0, `MdReady`=0.
  - FIFO empty; pending vector all zero.
- Reset asserted mid-operation: FIFO contents and pending bits are lost. The pipeline flushes together with this block.
- ALU latency: input in cycle N → port driven in cycle N+1. The register file writes at the falling edge of N+1.
- Mul/div latency with the FIFO empty and no ALU traffic: accept at edge k → port driven in the cycle after edge k+1 (2 cycles).
- FIFO order is strict arrival order; wrap-around uses `log2(DEPTH)`-bit pointers plus a count.
- `Hazard` reflects pending state after the most recent edge. A write being driven on the port in cycle N still shows as pending only if its clear has not yet occurred. Clear happens at the edge that registers the write, so `Hazard` drops in the same cycle the register file performs the write. Decode reads the register file only after the negedge, so it sees the new value.

## Structure
- Shared package `regfile_pkg`:
  - constants `REG_ZERO`=0, `REG_K0`=26, `REG_K1`=27, `REG_SP`=29;
  - function `reg_writable(addr)`;
  - address width 5, data width 32.
- One sub-module, `wb_fifo`: parameterised DEPTH × (5+32) synchronous FIFO with push, pop, full, empty and count.
- Arbitration, scoreboard and hold logic live in the top module.

## Test plan
- Reset: hold `Rst_n`=0 for 3 cycles with `AluValid`=1 and `MdValid`=1 → `RegWrite`=0, `MdReady`=0 and `Hazard`=0 throughout. One cycle after release, `MdReady`=1.
- ALU pass-through: `AluValid`=1, `AluWAddr`=8, `AluWData`=0x12345678 → next cycle `RegWrite`=1, `WAddr`=8, `WData`=0x12345678. The same test with `AluWAddr`=26 → `RegWrite`=0.
- Scoreboard:
  - `IssueMd` to $9, then `ReadReg2`=9 → `Hazard`=1;
  - push Md result ($9, −7) → port shows $9/−7 two cycles after accept;
  - `Hazard` falls in that same cycle.
- Contention: `AluValid` continuously plus 4 Md pushes to $10–$13 → FIFO fills, `MdReady`=0 and `AluHold`=1. While held, the head drains in order $10, $11, $12, $13 with no ALU write lost.
- Simultaneous set/clear: `IssueMd` to $5 in the same cycle the FIFO writes the previous $5 result → pending[5] remains 1 and `Hazard` stays high for `ReadReg1`=5.
- Discard: Md result to $0 accepted → never appears on the port, and FIFO count is unchanged.
